regbank_port_ctrl: RTL and testbench

- Client-side controller for the 16x16 register bank.
- Accepts operand-fetch requests and drives the bank read port. The bank samples its read port on negedge; data is valid at the following posedge.
- Returns operands over a valid/ready handshake.
- Accepts writeback results and drives the bank write port. The bank commits on posedge.
- Tracks pending destination registers in a busy scoreboard and stalls RAW/WAW hazards.

---
 rtl/regbank_port_ctrl.sv | 167 ++++++++++++++++
 tb/tb_regbank_port_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_port_ctrl.sv
// Purpose : client-side controller for the register bank (operand fetch, writeback, busy scoreboard).
// Latency : request accepted at posedge N gives op_valid from posedge N+1; a writeback commits one edge after its accept.
// Backpr. : req_ready drops outside IDLE or on a RAW/WAW hazard; op_* held until op_ready; wb_ready low while a write is in flight.
//
// Ports:
//   clock, reset                 : single clock; asynchronous active-low reset
//   req_* (valid/ready)          : fetch request carrying rs1, rs2, rd and the writeback-pending flag
//   op_*  (valid/ready)          : fetched operands plus the echoed rd and wb flag
//   wb_*  (valid/ready)          : writeback of wb_data into register wb_rd
//   rb_read, rb_reg1/2, rb_rdata1/2 : bank read port (bank samples on negedge, data valid at the next posedge)
//   rb_write, rb_ender, rb_wdata : bank write port (bank commits on posedge)
//   busy                         : scoreboard, bit i set while register i has a pending write
module regbank_port_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_rs1,
  input  logic [ADDR_W-1:0]     req_rs2,
  input  logic [ADDR_W-1:0]     req_rd,
  input  logic                  req_wb,

  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_W-1:0]     op_a,
  output logic [DATA_W-1:0]     op_b,
  output logic [ADDR_W-1:0]     op_rd,
  output logic                  op_wb,

  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_W-1:0]     wb_rd,
  input  logic [DATA_W-1:0]     wb_data,

  output logic                  rb_read,
  output logic [ADDR_W-1:0]     rb_reg1,
  output logic [ADDR_W-1:0]     rb_reg2,
  input  logic [DATA_W-1:0]     rb_rdata1,
  input  logic [DATA_W-1:0]     rb_rdata2,
  output logic                  rb_write,
  output logic [ADDR_W-1:0]     rb_ender,
  output logic [DATA_W-1:0]     rb_wdata,

  output logic [(2**ADDR_W)-1:0] busy
);

  localparam int NREG = 2**ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            hazard;
  logic            req_acc;
  logic            wb_acc;
  logic [NREG-1:0] busy_nxt;

  // A source still waiting for its writeback is a RAW hazard; a destination
  // that is already pending (when this request will write it too) is WAW.
  // No forwarding exists: the request simply waits for the commit edge.
  assign hazard    = busy[req_rs1] | busy[req_rs2] | (req_wb & busy[req_rd]);
  assign req_ready = (state == IDLE) & ~hazard;
  assign req_acc   = req_valid & req_ready;

  // One write in flight at a time keeps the commit/clear bookkeeping trivial.
  assign wb_ready  = ~rb_write;
  assign wb_acc    = wb_valid & wb_ready;

  // Fetch FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_acc)  state_nxt = READ;
      READ:                  state_nxt = HOLD;
      HOLD:    if (op_ready) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Scoreboard: the clear happens on the commit edge (rb_write high), and the
  // set is applied after it so a new pending write to the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (rb_write) begin
      busy_nxt[rb_ender] = 1'b0;
    end
    if (req_acc && req_wb) begin
      busy_nxt[req_rd] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch datapath: drive the bank read port on accept, capture the bank
  // data on the edge that leaves READ, hold it until the consumer takes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rb_read  <= 1'b0;
      rb_reg1  <= '0;
      rb_reg2  <= '0;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_rd    <= '0;
      op_wb    <= 1'b0;
    end else begin
      if (req_acc) begin
        rb_read <= 1'b1;
        rb_reg1 <= req_rs1;
        rb_reg2 <= req_rs2;
        op_rd   <= req_rd;
        op_wb   <= req_wb;
      end
      if (state == READ) begin
        // Bank sampled the read port on the mid-cycle negedge.
        rb_read  <= 1'b0;
        op_a     <= rb_rdata1;
        op_b     <= rb_rdata2;
        op_valid <= 1'b1;
      end
      if ((state == HOLD) && op_ready) begin
        op_valid <= 1'b0;
      end
    end
  end

  // Writeback datapath: a single-cycle pulse on the bank write port. Reset
  // drops any write still in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rb_write <= 1'b0;
      rb_ender <= '0;
      rb_wdata <= '0;
    end else begin
      if (wb_acc) begin
        rb_write <= 1'b1;
        rb_ender <= wb_rd;
        rb_wdata <= wb_data;
      end else begin
        rb_write <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_regbank_port_ctrl.sv
module tb_regbank_port_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wb;
  logic [3:0]  req_rs1, req_rs2, req_rd;
  logic        op_valid, op_ready, op_wb;
  logic [15:0] op_a, op_b;
  logic [3:0]  op_rd;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        rb_read, rb_write;
  logic [3:0]  rb_reg1, rb_reg2, rb_ender;
  logic [15:0] rb_rdata1, rb_rdata2, rb_wdata;
  logic [15:0] busy;

  always #5 clock = ~clock;

  regbank_port_ctrl #(.DATA_W(16), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rd(req_rd), .req_wb(req_wb),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .op_rd(op_rd), .op_wb(op_wb),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rb_read(rb_read), .rb_reg1(rb_reg1), .rb_reg2(rb_reg2),
    .rb_rdata1(rb_rdata1), .rb_rdata2(rb_rdata2),
    .rb_write(rb_write), .rb_ender(rb_ender), .rb_wdata(rb_wdata),
    .busy(busy)
  );

  // Register bank model: samples the read port on negedge, commits on posedge.
  logic        bank_clr;
  logic [15:0] bank [16];

  always @(negedge clock) begin
    if (rb_read) begin
      rb_rdata1 <= bank[rb_reg1];
      rb_rdata2 <= bank[rb_reg2];
    end
  end

  always @(posedge clock) begin
    if (bank_clr) begin
      for (int i = 0; i < 16; i++) bank[i] <= 16'h0000;
    end else if (rb_write) begin
      bank[rb_ender] <= rb_wdata;
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  rd;
    logic        wb;
  } op_exp_t;

  typedef struct {
    logic [3:0]  wrd;
    logic [15:0] wdat;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  op_exp_t expq[$];
  vec_t    tbl[6];
  int      total = 0;
  int      bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic do_wb(input logic [3:0] rd, input logic [15:0] d);
    int n = 0;
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    @(negedge clock);
    while (!wb_ready && n < 40) begin
      n++;
      @(negedge clock);
    end
    if (!wb_ready) chk("wb_accept_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    wb_valid = 1'b0;
  endtask

  // Called just after a posedge; pushes the expected operands on accept and
  // checks the one-cycle fetch latency; returns just after a posedge.
  task automatic do_fetch(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                          input logic wb, input logic [15:0] ea, input logic [15:0] eb);
    int n = 0;
    req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_wb = wb;
    @(negedge clock);
    while (!req_ready && n < 40) begin
      n++;
      @(negedge clock);
    end
    if (!req_ready) begin
      chk("req_accept_timeout", 32'd0, 32'd1);
      @(posedge clock); #1;
      req_valid = 1'b0;
      return;
    end
    expq.push_back('{ea, eb, rd, wb});
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("read_issue", {31'd0, rb_read}, 32'd1);
    chk("read_reg1", {28'd0, rb_reg1}, {28'd0, rs1});
    chk("read_reg2", {28'd0, rb_reg2}, {28'd0, rs2});
    chk("op_valid_in_read", {31'd0, op_valid}, 32'd0);
    @(negedge clock);
    chk("op_valid_after_1", {31'd0, op_valid}, 32'd1);
    @(posedge clock); #1;
  endtask

  initial begin
    tbl[0] = '{4'd0,  16'h0001, 4'd0,  4'd3,  4'd1, 16'h0001, 16'hBEEF};
    tbl[1] = '{4'd15, 16'hFFFF, 4'd15, 4'd0,  4'd2, 16'hFFFF, 16'h0001};
    tbl[2] = '{4'd3,  16'hA5A5, 4'd3,  4'd15, 4'd3, 16'hA5A5, 16'hFFFF};
    tbl[3] = '{4'd8,  16'h8000, 4'd8,  4'd8,  4'd4, 16'h8000, 16'h8000};
    tbl[4] = '{4'd1,  16'h0F0F, 4'd2,  4'd1,  4'd5, 16'h2222, 16'h0F0F};
    tbl[5] = '{4'd15, 16'h0000, 4'd15, 4'd5,  4'd6, 16'h0000, 16'h1234};

    reset = 1'b0; bank_clr = 1'b1;
    req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_wb = 1'b0;
    op_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;

    // Operand monitor: pops the scoreboard whenever a handshake completes.
    fork
      forever begin
        op_exp_t e;
        @(negedge clock);
        if (reset && op_valid && op_ready) begin
          if (expq.size() == 0) begin
            chk("op_unexpected", 32'd1, 32'd0);
          end else begin
            e = expq.pop_front();
            chk("op_a", {16'd0, op_a}, {16'd0, e.a});
            chk("op_b", {16'd0, op_b}, {16'd0, e.b});
            chk("op_rd", {28'd0, op_rd}, {28'd0, e.rd});
            chk("op_wb", {31'd0, op_wb}, {31'd0, e.wb});
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_rb_read", {31'd0, rb_read}, 32'd0);
    chk("rst_rb_write", {31'd0, rb_write}, 32'd0);
    chk("rst_busy", {16'd0, busy}, 32'd0);
    chk("rst_wb_ready", {31'd0, wb_ready}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b1; bank_clr = 1'b0;
    @(posedge clock); #1;

    // Single writeback pulse, then fetch it back
    do_wb(4'd3, 16'hBEEF);
    @(negedge clock);
    chk("wb_pulse_on", {31'd0, rb_write}, 32'd1);
    chk("wb_ender", {28'd0, rb_ender}, 32'd3);
    chk("wb_wdata", {16'd0, rb_wdata}, 32'h0000BEEF);
    @(negedge clock);
    chk("wb_pulse_off", {31'd0, rb_write}, 32'd0);
    @(posedge clock); #1;
    do_fetch(4'd3, 4'd0, 4'd0, 1'b0, 16'hBEEF, 16'h0000);

    // RAW stall on a pending destination
    do_fetch(4'd3, 4'd0, 4'd5, 1'b1, 16'hBEEF, 16'h0000);
    @(negedge clock);
    chk("busy5_set", {16'd0, busy}, 32'h00000020);
    req_valid = 1'b1; req_rs1 = 4'd5; req_rs2 = 4'd3; req_rd = 4'd9; req_wb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("raw_stall", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    do_wb(4'd5, 16'h1234);
    @(negedge clock);
    chk("raw_commit_cycle_ready", {31'd0, req_ready}, 32'd0);
    chk("raw_commit_cycle_busy", {16'd0, busy}, 32'h00000020);
    @(negedge clock);
    chk("raw_after_commit_busy", {16'd0, busy}, 32'd0);
    chk("raw_after_commit_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clock); #1;
    do_fetch(4'd5, 4'd3, 4'd9, 1'b0, 16'h1234, 16'hBEEF);

    // Consumer backpressure, rs1 == rs2
    op_ready = 1'b0;
    do_fetch(4'd3, 4'd3, 4'd2, 1'b0, 16'hBEEF, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("hold_valid", {31'd0, op_valid}, 32'd1);
      chk("hold_op_a", {16'd0, op_a}, 32'h0000BEEF);
      chk("hold_op_b", {16'd0, op_b}, 32'h0000BEEF);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clock); #1;
    op_ready = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("release_valid", {31'd0, op_valid}, 32'd0);
    chk("release_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clock); #1;

    // Back-to-back writebacks are spaced two cycles apart
    wb_valid = 1'b1; wb_rd = 4'd1; wb_data = 16'h1111;
    @(negedge clock);
    chk("b2b_ready_first", {31'd0, wb_ready}, 32'd1);
    @(posedge clock); #1;
    wb_rd = 4'd2; wb_data = 16'h2222;
    @(negedge clock);
    chk("b2b_ready_second", {31'd0, wb_ready}, 32'd0);
    chk("b2b_pulse1", {31'd0, rb_write}, 32'd1);
    chk("b2b_ender1", {28'd0, rb_ender}, 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("b2b_gap", {31'd0, rb_write}, 32'd0);
    chk("b2b_ready_again", {31'd0, wb_ready}, 32'd1);
    @(posedge clock); #1;
    wb_valid = 1'b0;
    @(negedge clock);
    chk("b2b_pulse2", {31'd0, rb_write}, 32'd1);
    chk("b2b_ender2", {28'd0, rb_ender}, 32'd2);
    @(posedge clock); #1;
    do_fetch(4'd1, 4'd2, 4'd10, 1'b0, 16'h1111, 16'h2222);

    // Dispatch rd=7 on the commit edge of a plain write to reg 7: set wins
    wb_valid = 1'b1; wb_rd = 4'd7; wb_data = 16'h7777;
    @(negedge clock);
    chk("setwin_wb_ready", {31'd0, wb_ready}, 32'd1);
    @(posedge clock); #1;
    wb_valid = 1'b0;
    req_valid = 1'b1; req_rs1 = 4'd7; req_rs2 = 4'd7; req_rd = 4'd7; req_wb = 1'b1;
    @(negedge clock);
    chk("setwin_req_ready", {31'd0, req_ready}, 32'd1);
    chk("setwin_commit", {31'd0, rb_write}, 32'd1);
    chk("setwin_ender", {28'd0, rb_ender}, 32'd7);
    expq.push_back('{16'h7777, 16'h7777, 4'd7, 1'b1});
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("setwin_busy", {16'd0, busy}, 32'h00000080);
    repeat (3) @(posedge clock);
    #1;
    do_wb(4'd7, 16'h7007);
    @(posedge clock); #1;
    @(negedge clock);
    chk("busy7_cleared", {16'd0, busy}, 32'd0);
    @(posedge clock); #1;

    // Table-driven writeback + fetch pairs
    for (int i = 0; i < 6; i++) begin
      do_wb(tbl[i].wrd, tbl[i].wdat);
      do_fetch(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, 1'b0, tbl[i].ea, tbl[i].eb);
    end

    // Asynchronous reset mid-READ with a write in flight
    wb_valid = 1'b1; wb_rd = 4'd4; wb_data = 16'h4444;
    req_valid = 1'b1; req_rs1 = 4'd0; req_rs2 = 4'd0; req_rd = 4'd4; req_wb = 1'b1;
    @(negedge clock);
    chk("pre_rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clock); #1;
    wb_valid = 1'b0; req_valid = 1'b0; req_wb = 1'b0;
    chk("pre_rst_read", {31'd0, rb_read}, 32'd1);
    chk("pre_rst_write", {31'd0, rb_write}, 32'd1);
    chk("pre_rst_busy", {16'd0, busy}, 32'h00000010);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_read", {31'd0, rb_read}, 32'd0);
    chk("arst_write", {31'd0, rb_write}, 32'd0);
    chk("arst_busy", {16'd0, busy}, 32'd0);
    chk("arst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("arst_op_b", {16'd0, op_b}, 32'd0);
    chk("arst_ender", {28'd0, rb_ender}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_op_valid", {31'd0, op_valid}, 32'd0);
    @(posedge clock); #1;
    // The dropped write must never have reached the bank.
    do_fetch(4'd4, 4'd4, 4'd0, 1'b0, 16'h0000, 16'h0000);

    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_drained", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
